// File: rtl/hilo_div_pkg.sv
// Shared defines for the HI/LO divider: register width, reset level, FSM encodings
// and handshake levels.
package hilo_div_pkg;

  localparam int RegBus = 32;

  localparam logic              RstEnable         = 1'b1;
  localparam logic [RegBus-1:0] ZeroWord          = 32'h0000_0000;
  localparam logic              DivResultReady    = 1'b1;
  localparam logic              DivResultNotReady = 1'b0;
  localparam logic              DivStart          = 1'b1;
  localparam logic              DivStop           = 1'b0;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

endpackage

// File: rtl/hilo_div_if.sv
// Request/result bundle between the EX decoder (master) and the divider (slave).
interface hilo_div_if;

  logic                              start_i;
  logic                              signed_div_i;
  logic [hilo_div_pkg::RegBus-1:0]   opdata1_i;
  logic [hilo_div_pkg::RegBus-1:0]   opdata2_i;
  logic                              annul_i;
  logic                              ready_o;
  logic                              hilo_we_o;
  logic [hilo_div_pkg::RegBus-1:0]   hi_o;
  logic [hilo_div_pkg::RegBus-1:0]   lo_o;
  logic                              stallreq_o;

  modport master (
    output start_i, signed_div_i, opdata1_i, opdata2_i, annul_i,
    input  ready_o, hilo_we_o, hi_o, lo_o, stallreq_o
  );

  modport slave (
    input  start_i, signed_div_i, opdata1_i, opdata2_i, annul_i,
    output ready_o, hilo_we_o, hi_o, lo_o, stallreq_o
  );

endinterface

// File: rtl/hilo_div_step.sv
// One restoring-division iteration on the 65-bit working register
// (partial remainder in [64:33], remaining dividend / quotient bits below).
module hilo_div_step
  import hilo_div_pkg::*;
(
  input  logic [64:0]       w,
  input  logic [RegBus-1:0] divisor,
  output logic [64:0]       w_next
);

  logic              ge_s;
  logic [RegBus-1:0] rem_s;

  // Trial subtract: the 33-bit minuend is compared in full, but a successful
  // difference is always below the divisor, so its low 32 bits are exact.
  always_comb begin
    ge_s  = (w[64:32] >= {1'b0, divisor});
    rem_s = w[63:32] - divisor;
    if (ge_s) begin
      w_next = {rem_s, w[31:0], 1'b1};
    end else begin
      w_next = {w[63:0], 1'b0};
    end
  end

endmodule

// File: rtl/hilo_div.sv
// Iterative 32-bit divider feeding HI (remainder) and LO (quotient).
// Build option HILO_DIV_SIGNED_EN enables signed DIV; otherwise every divide is unsigned.
module hilo_div
  import hilo_div_pkg::*;
(
  input logic       clk,
  input logic       rst,
  hilo_div_if.slave bus
);

  div_state_e        state_r;
  logic [5:0]        cnt_r;
  logic [64:0]       w_r;
  logic [64:0]       w_next_s;
  logic [RegBus-1:0] divisor_r;
  logic              ready_r;
  logic              we_r;
  logic [RegBus-1:0] hi_r;
  logic [RegBus-1:0] lo_r;
  logic [RegBus-1:0] abs_a_s;
  logic [RegBus-1:0] abs_b_s;
  logic [RegBus-1:0] quot_s;
  logic [RegBus-1:0] rem_s;
  logic              accept_s;
`ifdef HILO_DIV_SIGNED_EN
  logic              neg_q_s;
  logic              neg_r_s;
  logic              neg_q_r;
  logic              neg_r_r;
`endif

  hilo_div_step u_step (
    .w       (w_r),
    .divisor (divisor_r),
    .w_next  (w_next_s)
  );

  // Operand magnitudes and result sign flags, evaluated on the accept cycle
  always_comb begin
    abs_a_s = bus.opdata1_i;
    abs_b_s = bus.opdata2_i;
`ifdef HILO_DIV_SIGNED_EN
    neg_q_s = 1'b0;
    neg_r_s = 1'b0;
    if (bus.signed_div_i) begin
      if (bus.opdata1_i[31]) begin
        abs_a_s = ZeroWord - bus.opdata1_i;
      end else begin
        abs_a_s = bus.opdata1_i;
      end
      if (bus.opdata2_i[31]) begin
        abs_b_s = ZeroWord - bus.opdata2_i;
      end else begin
        abs_b_s = bus.opdata2_i;
      end
      neg_q_s = bus.opdata1_i[31] ^ bus.opdata2_i[31];
      neg_r_s = bus.opdata1_i[31];
    end else begin
      neg_q_s = 1'b0;
      neg_r_s = 1'b0;
    end
`endif
  end

  // Final quotient/remainder taken from the last iteration, with sign fix-up
  always_comb begin
    quot_s = w_next_s[31:0];
    rem_s  = w_next_s[64:33];
`ifdef HILO_DIV_SIGNED_EN
    if (neg_q_r) begin
      quot_s = ZeroWord - w_next_s[31:0];
    end else begin
      quot_s = w_next_s[31:0];
    end
    if (neg_r_r) begin
      rem_s = ZeroWord - w_next_s[64:33];
    end else begin
      rem_s = w_next_s[64:33];
    end
`endif
  end

  assign accept_s = (bus.start_i == DivStart) && !bus.annul_i;

  // Divider FSM, iteration counter, working register and registered results
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_r   <= DivFree;
      cnt_r     <= 6'd0;
      w_r       <= 65'd0;
      divisor_r <= ZeroWord;
      ready_r   <= DivResultNotReady;
      we_r      <= 1'b0;
      hi_r      <= ZeroWord;
      lo_r      <= ZeroWord;
`ifdef HILO_DIV_SIGNED_EN
      neg_q_r   <= 1'b0;
      neg_r_r   <= 1'b0;
`endif
    end else begin
      case (state_r)
        DivFree: begin
          ready_r <= DivResultNotReady;
          we_r    <= 1'b0;
          hi_r    <= ZeroWord;
          lo_r    <= ZeroWord;
          if (accept_s) begin
            cnt_r     <= 6'd0;
            w_r       <= {32'd0, abs_a_s, 1'b0};
            divisor_r <= abs_b_s;
`ifdef HILO_DIV_SIGNED_EN
            neg_q_r   <= neg_q_s;
            neg_r_r   <= neg_r_s;
`endif
            if (bus.opdata2_i == ZeroWord) begin
              state_r <= DivByZero;
            end else begin
              state_r <= DivOn;
            end
          end else begin
            state_r <= DivFree;
          end
        end
        DivByZero: begin
          if (bus.annul_i) begin
            state_r <= DivFree;
          end else begin
            state_r <= DivEnd;
            ready_r <= DivResultReady;
            we_r    <= 1'b1;
            hi_r    <= ZeroWord;
            lo_r    <= ZeroWord;
          end
        end
        DivOn: begin
          if (bus.annul_i) begin
            state_r <= DivFree;
          end else begin
            w_r   <= w_next_s;
            cnt_r <= cnt_r + 6'd1;
            // 32nd iteration lands its result directly in the output registers
            if (cnt_r == 6'd31) begin
              state_r <= DivEnd;
              ready_r <= DivResultReady;
              we_r    <= 1'b1;
              hi_r    <= rem_s;
              lo_r    <= quot_s;
            end else begin
              state_r <= DivOn;
            end
          end
        end
        DivEnd: begin
          we_r <= 1'b0;
          if (bus.annul_i || (bus.start_i == DivStop)) begin
            state_r <= DivFree;
            ready_r <= DivResultNotReady;
            hi_r    <= ZeroWord;
            lo_r    <= ZeroWord;
          end else begin
            state_r <= DivEnd;
          end
        end
        default: begin
          state_r <= DivFree;
        end
      endcase
    end
  end

  assign bus.ready_o    = ready_r;
  assign bus.hilo_we_o  = we_r & ~bus.annul_i;
  assign bus.hi_o       = hi_r;
  assign bus.lo_o       = lo_r;
  assign bus.stallreq_o = ((state_r == DivFree) && accept_s) ||
                          (state_r == DivByZero) || (state_r == DivOn);

endmodule

// File: doc/hilo_div.md
# hilo_div

Iterative 32-bit divider in the execute stage; the producer side of the HI/LO register interface. It accepts a divide request from the EX decoder, runs a radix-2 restoring division over 32 cycles, and writes the result back: remainder to HI, quotient to LO. While the operation is in flight it asserts a stall request, so the pipeline holds the dividing instruction in EX.

## Interface
- `RegBus`: width 32. Operand and HI/LO width, taken from the shared defines.
- `clk`  in  1  sole clock; all state updates on posedge.
- `rst`  in  1  synchronous, active-high reset (`RstEnable` = 1).
- `start_i`  in  1  divide request; issuer holds it high until `ready_o`.
- `signed_div_i`  in  1  1 = signed (DIV), 0 = unsigned (DIVU).
- `opdata1_i`  in  32  dividend; sampled only on the accept cycle.
- `opdata2_i`  in  32  divisor; sampled only on the accept cycle.
- `annul_i`  in  1  cancel the in-flight division (flush or exception).
- `ready_o`  out  1  result valid; stays high while in End.
- `hilo_we_o`  out  1  HI/LO write enable; one-cycle pulse.
- `hi_o`  out  32  remainder to HI.
- `lo_o`  out  32  quotient to LO.
- `stallreq_o`  out  1  pipeline stall request.

## Operation
- FSM states (2 bits): Free, ByZero, On, End.
- Free:
  - If `start_i` and not `annul_i`, latch the operands and clear the counter.
  - If the divisor is 0, go to ByZero; otherwise go to On.
- ByZero: result forced to hi = lo = 0; go to End next cycle.
- On:
  - 65-bit working register W, initialised to {32'b0, |dividend|, 1'b0}.
  - Each cycle, D = W[64:32] − {1'b0, |divisor|} (33-bit).
  - If D is negative: W ← W << 1. Otherwise: W ← {D[31:0], W[31:0], 1'b1}.
  - 6-bit counter increments each cycle. When it reaches 32, go to End.
  - Quotient = W[31:0]. Remainder = W[64:33].
- Signed division:
  - Negative operands are two's-complement negated on accept.
  - Quotient is negated when the operand signs differ.
  - Remainder takes the sign of the dividend.
  - Unsigned division skips all negation.
- End:
  - `ready_o` = 1; `hi_o`/`lo_o` hold the final values.
  - `hilo_we_o` = 1 only in the first End cycle.
  - Go to Free when `start_i` = 0; stay in End otherwise.
- `annul_i` in On or ByZero: go to Free next cycle. No write, outputs stay zero.
- `annul_i` in End: suppresses `hilo_we_o` for that cycle and goes to Free.
- `stallreq_o` = 1 when:
  - (Free and `start_i` and not `annul_i`), or
  - in ByZero, or
  - in On.
- `stallreq_o` = 0 in End.
- Reset (any state, including mid-operation): state Free, counter 0, W 0. All outputs 0 on the next edge.

## Timing
- Accept at edge T (Free, `start_i` = 1). In cycle T the stall is combinational from `start_i`.
- Normal path:
  - On for cycles T+1 … T+32.
  - End at T+33: `ready_o`, `hilo_we_o`, `hi_o`, `lo_o` all registered and valid.
- Divide-by-zero path: ByZero at T+1, End at T+2.
- Earliest back-to-back accept is one cycle after `start_i` falls in End.
- Operand changes after the accept cycle have no effect.

## Configuration
- Macro: `HILO_DIV_SIGNED_EN`.
- Defined: signed division as described above.
- Undefined:
  - `signed_div_i` is ignored and all divisions are unsigned.
  - Negation and sign-fixup logic is removed.
  - Interface is unchanged.

## Structure
- Shared defines package:
  - `RegBus`.
  - `RstEnable`.
  - `ZeroWord`.
  - State encodings `DivFree` 2'b00, `DivByZero` 2'b01, `DivOn` 2'b10, `DivEnd` 2'b11.
  - `DivResultReady` / `DivResultNotReady`.
  - `DivStart` / `DivStop`.
- Sub-module: `hilo_div_step`, a combinational single iteration (W in, W out, 33-bit subtract).
- FSM, counter, sign handling and output registers live in `hilo_div`.

## Test plan
- Unsigned 100 ÷ 7, accept at T → at T+33, lo = 14, hi = 2, `hilo_we_o` high for 1 cycle; `stallreq_o` low at T+33.
- Signed −7 ÷ 2 (0xFFFFFFF9, 2) → lo = 0xFFFFFFFD, hi = 0xFFFFFFFF. With the macro undefined, the same operands give lo = 0x7FFFFFFC, hi = 1.
- Divisor 0 at T → End at T+2, hi = lo = 0, `hilo_we_o` pulsed once.
- Start at T, `annul_i` at T+10 → Free at T+11; no `hilo_we_o` pulse; a new start at T+12 completes correctly at T+45.
- `rst` at T+20 mid-division → all outputs 0 at T+21, state Free; `start_i` held in End for 3 cycles → exactly one `hilo_we_o` pulse.
